spice_bus_reader: RTL and testbench
===================================

# spice_bus_reader

Samples a group of simulated-netlist node voltages and delivers them to the FPGA-side logic as one qualified digital word. It is the read direction of the pin interface: the pin input models turn host bits into node currents, and this block turns node voltages back into bits. It adds hysteresis per bit and a settle check across the whole bus, then hands the word over on a valid/ready handshake. Typical use is capturing the simulated CPU's address and data buses once per phase, triggered by the host-side phase sequencer.

## Interface
Parameters:
- N, 8: number of pins (word width).
- SETTLE, 4: consecutive stable eclk cycles required before capture; range 1..255.
- TIMEOUT, 64: maximum eclk cycles spent waiting before a forced capture; range 2..65535, and must exceed SETTLE.
- TH_HI, `TH_HI: upper threshold, signed `W bits.
- TH_LO, `TH_LO: lower threshold, signed `W bits, with TH_LO < TH_HI.

Ports:
- eclk  input  1  emulation clock; the single clock domain.
- ereset_n  input  1  asynchronous, active-low reset.
- v  input  N*`W  node voltages, signed; pin i occupies bits [i*`W +: `W].
- req  input  1  capture request, sampled each eclk.
- data  output  N  captured word.
- valid  output  1  data available.
- ready  input  1  consumer accepts data.
- timeout  output  1  the current data was force-captured without settling; valid only while valid=1.
- overrun  output  1  sticky flag: a req arrived while the block was busy.
- clr_overrun  input  1  synchronous clear of overrun.

## Operation
- Reset values: data=0, valid=0, timeout=0, overrun=0, all level registers 0, stable_cnt=0, state IDLE.
- Per-bit hysteresis, registered each cycle:
  - v >= TH_HI sets level=1.
  - v <= TH_LO sets level=0.
  - Any value in between holds level and marks the bit unresolved.
  - All comparisons are signed, full `W-bit.
- stable_cnt (8 bits, saturates at SETTLE):
  - Cleared in any cycle where any bit is unresolved or any level changed.
  - Otherwise increments.
  - Runs free in every state.
- The bus is "stable" when stable_cnt >= SETTLE.
- States IDLE, WAIT, HOLD:
  - IDLE: req=1 moves to WAIT and clears wait_cnt.
  - WAIT, stable: data <= levels, timeout <= 0, valid <= 1, go to HOLD.
  - WAIT, not stable and wait_cnt == TIMEOUT-1: data <= levels, timeout <= 1, valid <= 1, go to HOLD.
  - WAIT, neither condition: wait_cnt increments.
  - HOLD: data and timeout stay frozen. valid&&ready completes the transfer, valid <= 0, go to IDLE.
- Boundary cases:
  - If stable and the timeout limit occur in the same cycle, stable wins and timeout=0.
  - req in HOLD together with valid&&ready: the request is accepted and the next state is WAIT, not IDLE. overrun is not set.
  - req in WAIT, or req in HOLD without the handshake completing: overrun <= 1 and the request is dropped.
  - clr_overrun and a new overrun event in the same cycle: the set wins.
  - Mid-operation ereset_n low: all state returns to reset values immediately. Any in-flight request is lost.

## Timing
- Level registers lag v by one eclk; stable_cnt lags the level registers by one eclk.
- Minimum latency, bus already stable: req high at edge k, WAIT at k, valid=1 after edge k+1. That is two cycles from req to valid.
- Settling case: valid=1 no later than SETTLE+2 cycles after the last bit transition, provided this falls inside the timeout window.
- Forced capture: valid=1 exactly TIMEOUT cycles after the req edge.
- The handshake uses no combinational paths: valid, data and timeout are all registers, and ready only affects the next state.
- Maximum throughput: one word per 2 cycles, with req held high and ready held high.

## Structure
- common.h gains `TH_HI (default `HI/2) and `TH_LO (default `LO/2), plus state-encoding macros for IDLE, WAIT and HOLD.
- Sub-module spice_pin_schmitt handles one bit: inputs eclk, ereset_n and v; outputs level and resolved. It is instantiated N times in a generate loop.
- The top level holds stable_cnt, wait_cnt, the FSM and the output registers.

## Test plan
All scenarios use N=8, SETTLE=4, TIMEOUT=64.
- Stable capture: drive every pin to `HI except pins 0 and 7 at `LO for 10 cycles, then pulse req with ready=1 → valid high 2 cycles after req, data=8'h7E, timeout=0.
- Slow edge: ramp pin 3 from `LO to `HI over 20 cycles while req is already pending → no valid until stable_cnt reaches 4; data bit3=1 and timeout=0.
- Stuck midpoint: hold pin 5 at 0 (between the thresholds), then req → valid exactly 64 cycles after req, timeout=1, bit5 equals its prior level.
- Backpressure and overrun:
  - Capture with ready=0, then pulse req twice while in HOLD → data unchanged, overrun=1.
  - Next, req together with ready=1 → WAIT entered, and overrun is not newly set by that request.
  - clr_overrun=1 → overrun=0.
- Hysteresis: move pin 1 through `HI, TH_HI-1, TH_LO+1, then `LO → level stays 1 until v <= TH_LO, and stable_cnt is cleared while the value sits between the thresholds.
- Async reset: assert ereset_n=0 mid-WAIT and in HOLD (between eclk edges) → valid, data, timeout and overrun go to 0 immediately; after release, req works normally.

Source files
------------

// File: rtl/spice_bus_reader_pkg.sv
// Shared constants and state encoding for the node-voltage bus reader.
package spice_bus_reader_pkg;

  // Node-voltage word width and nominal rail levels (signed).
  localparam int W = 16;
  localparam logic signed [W-1:0] V_HI = 16'sd4000;
  localparam logic signed [W-1:0] V_LO = -16'sd4000;

  // Default hysteresis thresholds sit halfway to each rail.
  localparam logic signed [W-1:0] TH_HI_DEF = V_HI / 2;
  localparam logic signed [W-1:0] TH_LO_DEF = V_LO / 2;

  // Capture sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/spice_pin_schmitt.sv
// One-bit Schmitt comparator: registers a hysteretic level for one node
// voltage and flags whether the voltage sat outside the dead band.
module spice_pin_schmitt
  import spice_bus_reader_pkg::*;
#(
  parameter logic signed [W-1:0] TH_HI = TH_HI_DEF,
  parameter logic signed [W-1:0] TH_LO = TH_LO_DEF
) (
  input  logic         eclk,
  input  logic         ereset_n,
  input  logic [W-1:0] v,
  output logic         level,
  output logic         resolved
);

  logic signed [W-1:0] v_s;
  logic level_q, level_d;
  logic resolved_q, resolved_d;

  assign v_s = $signed(v);

  // Threshold decision: in the dead band the old level is kept.
  always_comb begin
    level_d    = level_q;
    resolved_d = 1'b0;
    if (v_s >= TH_HI) begin
      level_d    = 1'b1;
      resolved_d = 1'b1;
    end else if (v_s <= TH_LO) begin
      level_d    = 1'b0;
      resolved_d = 1'b1;
    end
  end

  // Level and resolution registers.
  always_ff @(posedge eclk or negedge ereset_n) begin
    if (!ereset_n) begin
      level_q    <= 1'b0;
      resolved_q <= 1'b0;
    end else begin
      level_q    <= level_d;
      resolved_q <= resolved_d;
    end
  end

  assign level    = level_q;
  assign resolved = resolved_q;

endmodule

// File: rtl/spice_bus_reader.sv
// Bus reader: per-pin hysteresis, whole-bus settle detection, and a
// request-driven capture sequencer with a valid/ready output register.
//
// state   | meaning
// IDLE    | no capture pending, waiting for req
// WAIT    | capture requested, waiting for the bus to settle or time out
// HOLD    | word presented on data with valid=1 until the consumer takes it
module spice_bus_reader
  import spice_bus_reader_pkg::*;
#(
  parameter int N       = 8,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 64,
  parameter logic signed [W-1:0] TH_HI = TH_HI_DEF,
  parameter logic signed [W-1:0] TH_LO = TH_LO_DEF
) (
  input  logic           eclk,
  input  logic           ereset_n,
  input  logic [N*W-1:0] v,
  input  logic           req,
  output logic [N-1:0]   data,
  output logic           valid,
  input  logic           ready,
  output logic           timeout,
  output logic           overrun,
  input  logic           clr_overrun
);

  logic [N-1:0] levels, resolved, levels_prev_q;
  logic [7:0]   stable_cnt_q, stable_cnt_d;
  logic [15:0]  wait_cnt_q, wait_cnt_d;
  logic         quiet, stable, ovr_set;
  state_e       state_q, state_d;
  logic [N-1:0] data_q, data_d;
  logic         valid_q, valid_d;
  logic         timeout_q, timeout_d;
  logic         overrun_q, overrun_d;

  for (genvar gi = 0; gi < N; gi++) begin : g_pin
    spice_pin_schmitt #(
      .TH_HI(TH_HI),
      .TH_LO(TH_LO)
    ) u_pin (
      .eclk    (eclk),
      .ereset_n(ereset_n),
      .v       (v[gi*W +: W]),
      .level   (levels[gi]),
      .resolved(resolved[gi])
    );
  end

  // Count consecutive quiet cycles (all resolved, no level change), saturating.
  always_comb begin
    quiet        = (&resolved) && (levels == levels_prev_q);
    stable_cnt_d = stable_cnt_q;
    if (!quiet) begin
      stable_cnt_d = '0;
    end else if (stable_cnt_q < 8'(SETTLE)) begin
      stable_cnt_d = stable_cnt_q + 8'd1;
    end
  end

  assign stable = (stable_cnt_q >= 8'(SETTLE));

  // Settle-tracking registers; they run regardless of sequencer state.
  always_ff @(posedge eclk or negedge ereset_n) begin
    if (!ereset_n) begin
      levels_prev_q <= '0;
      stable_cnt_q  <= '0;
    end else begin
      levels_prev_q <= levels;
      stable_cnt_q  <= stable_cnt_d;
    end
  end

  // Sequencer next state and output-register updates.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    data_d     = data_q;
    valid_d    = valid_q;
    timeout_d  = timeout_q;
    ovr_set    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d    = ST_WAIT;
          wait_cnt_d = '0;
        end
      end
      ST_WAIT: begin
        ovr_set = req;
        // A settled bus takes priority over the forced capture.
        if (stable || (wait_cnt_q == 16'(TIMEOUT - 1))) begin
          data_d    = levels;
          timeout_d = !stable;
          valid_d   = 1'b1;
          state_d   = ST_HOLD;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      ST_HOLD: begin
        if (valid_q && ready) begin
          valid_d = 1'b0;
          if (req) begin
            state_d    = ST_WAIT;
            wait_cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          ovr_set = req;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (ovr_set) begin
      overrun_d = 1'b1;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Sequencer state and output registers.
  always_ff @(posedge eclk or negedge ereset_n) begin
    if (!ereset_n) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
      overrun_q  <= overrun_d;
    end
  end

  assign data    = data_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_spice_bus_reader.sv
// Self-checking bench for spice_bus_reader: scenario table, hand-written
// corner sequences, and randomized traffic against a reference model.
module tb_spice_bus_reader;
  import spice_bus_reader_pkg::*;

  localparam int N       = 8;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 64;

  logic           eclk;
  logic           ereset_n;
  logic [N*W-1:0] v;
  logic           req;
  logic [N-1:0]   data;
  logic           valid;
  logic           ready;
  logic           timeout;
  logic           overrun;
  logic           clr_overrun;

  int n_cmp = 0;
  int n_bad = 0;

  spice_bus_reader #(
    .N(N), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .eclk       (eclk),
    .ereset_n   (ereset_n),
    .v          (v),
    .req        (req),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .timeout    (timeout),
    .overrun    (overrun),
    .clr_overrun(clr_overrun)
  );

  initial eclk = 1'b0;
  always #5 eclk = ~eclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Levels follow the threshold rules; "settled" means the bus has been
  // resolved and unchanged for SETTLE observed cycles; captures happen on
  // settle or when TIMEOUT cycles have elapsed since the request was taken.
  logic [N-1:0] m_lev, m_lev_prev, m_data;
  bit           m_res_all, m_valid, m_to, m_ovr;
  int           m_run, m_phase, m_t0, cyc;   // phase: 0 idle, 1 waiting, 2 presenting

  task automatic model_reset();
    m_lev = '0; m_lev_prev = '0; m_data = '0;
    m_res_all = 0; m_valid = 0; m_to = 0; m_ovr = 0;
    m_run = 0; m_phase = 0; m_t0 = 0;
  endtask

  task automatic model_edge();
    bit settled, ovr_set, nres;
    logic [N-1:0] nl;
    logic signed [W-1:0] sv;
    cyc++;
    if (!ereset_n) begin
      model_reset();
      return;
    end
    settled = (m_run >= SETTLE);
    ovr_set = 0;
    case (m_phase)
      0: if (req) begin m_phase = 1; m_t0 = cyc; end
      1: begin
        if (req) ovr_set = 1;
        if (settled || (cyc - m_t0 == TIMEOUT)) begin
          m_data = m_lev; m_to = !settled; m_valid = 1; m_phase = 2;
        end
      end
      default: begin
        if (ready) begin
          m_valid = 0;
          if (req) begin m_phase = 1; m_t0 = cyc; end
          else m_phase = 0;
        end else if (req) begin
          ovr_set = 1;
        end
      end
    endcase
    if (ovr_set) m_ovr = 1;
    else if (clr_overrun) m_ovr = 0;
    m_run = (m_res_all && (m_lev == m_lev_prev)) ? m_run + 1 : 0;
    nl = m_lev; nres = 1;
    for (int i = 0; i < N; i++) begin
      sv = v[i*W +: W];
      if (sv >= TH_HI_DEF) nl[i] = 1'b1;
      else if (sv <= TH_LO_DEF) nl[i] = 1'b0;
      else nres = 0;
    end
    m_lev_prev = m_lev;
    m_lev      = nl;
    m_res_all  = nres;
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge eclk);
    #1;
    check("mdl_valid", 32'(valid), 32'(m_valid));
    check("mdl_data", 32'(data), 32'(m_data));
    check("mdl_overrun", 32'(overrun), 32'(m_ovr));
    if (m_valid) check("mdl_timeout", 32'(timeout), 32'(m_to));
  endtask

  task automatic do_reset();
    ereset_n = 1'b0;
    #1;
    model_reset();
    step();
    step();
    ereset_n = 1'b1;
  endtask

  function automatic logic [N*W-1:0] mkbus(input logic [N-1:0] hi, input logic [N-1:0] mid);
    logic [N*W-1:0] b;
    for (int i = 0; i < N; i++)
      b[i*W +: W] = mid[i] ? {W{1'b0}} : (hi[i] ? V_HI : V_LO);
    return b;
  endfunction

  task automatic set_pin(input int i, input logic [W-1:0] val);
    v[i*W +: W] = val;
  endtask

  // lat = number of edges after the req-sampling edge until valid, -1 if none
  task automatic do_capture(input int max_c, output int lat);
    req = 1'b1; ready = 1'b1;
    step();
    req = 1'b0;
    lat = -1;
    for (int c = 1; c <= max_c; c++) begin
      step();
      if (valid === 1'b1) begin lat = c; break; end
    end
  endtask

  typedef struct {
    string          name;
    logic [N-1:0]   hi;
    logic [N-1:0]   mid;
    int             lat;
    logic [N-1:0]   exp_data;
    logic           exp_to;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int lat;
    logic [W-1:0] rv;

    ereset_n = 1'b0; v = '0; req = 1'b0; ready = 1'b0; clr_overrun = 1'b0;
    cyc = 0;
    model_reset();

    tbl[0] = '{name: "stable_7E",  hi: 8'h7E, mid: 8'h00, lat: 1,       exp_data: 8'h7E, exp_to: 1'b0};
    tbl[1] = '{name: "stable_00",  hi: 8'h00, mid: 8'h00, lat: 1,       exp_data: 8'h00, exp_to: 1'b0};
    tbl[2] = '{name: "stable_A5",  hi: 8'hA5, mid: 8'h00, lat: 1,       exp_data: 8'hA5, exp_to: 1'b0};
    tbl[3] = '{name: "stuck_pin5", hi: 8'hFF, mid: 8'h20, lat: TIMEOUT, exp_data: 8'hDF, exp_to: 1'b1};
    tbl[4] = '{name: "stuck_pin2", hi: 8'h00, mid: 8'h04, lat: TIMEOUT, exp_data: 8'h00, exp_to: 1'b1};

    // Reset state.
    do_reset();
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);

    // Scenario table.
    foreach (tbl[k]) begin
      do_reset();
      v = mkbus(tbl[k].hi, tbl[k].mid);
      repeat (10) step();
      do_capture(TIMEOUT + 4, lat);
      check({tbl[k].name, "_lat"}, 32'(lat), 32'(tbl[k].lat));
      check({tbl[k].name, "_data"}, 32'(data), 32'(tbl[k].exp_data));
      check({tbl[k].name, "_timeout"}, 32'(timeout), 32'(tbl[k].exp_to));
      step();
      check({tbl[k].name, "_released"}, 32'(valid), 32'd0);
    end

    // Slow edge on pin 3 with the request already pending.
    do_reset();
    v = mkbus(8'hF7, 8'h00);
    repeat (10) step();
    ready = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      set_pin(3, 16'(-4000 + 400 * j));
      req = (j == 9);
      step();
      req = 1'b0;
      if (j > 9) check("slow_no_valid", 32'(valid), 32'd0);
    end
    lat = -1;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (valid === 1'b1) begin lat = c; break; end
    end
    check("slow_settle_lat", 32'(lat), 32'd1);
    check("slow_data", 32'(data), 32'hFF);
    check("slow_timeout", 32'(timeout), 32'd0);
    step();

    // Backpressure and overrun.
    do_reset();
    v = mkbus(8'h3C, 8'h00);
    repeat (10) step();
    req = 1'b1; ready = 1'b0;
    step();
    req = 1'b0;
    repeat (3) step();
    check("bp_valid", 32'(valid), 32'd1);
    check("bp_data", 32'(data), 32'h3C);
    v = mkbus(8'hC3, 8'h00);
    step();
    req = 1'b1; step(); req = 1'b0; step();
    req = 1'b1; step(); req = 1'b0;
    check("bp_overrun_set", 32'(overrun), 32'd1);
    check("bp_data_frozen", 32'(data), 32'h3C);
    check("bp_still_valid", 32'(valid), 32'd1);
    req = 1'b1; clr_overrun = 1'b1; step(); req = 1'b0;
    check("bp_set_beats_clr", 32'(overrun), 32'd1);
    step(); clr_overrun = 1'b0;
    check("bp_clr", 32'(overrun), 32'd0);
    req = 1'b1; ready = 1'b1; step(); req = 1'b0; ready = 1'b0;
    check("bp_handoff_valid", 32'(valid), 32'd0);
    check("bp_handoff_no_ovr", 32'(overrun), 32'd0);
    step();
    check("bp_recapture_valid", 32'(valid), 32'd1);
    check("bp_recapture_data", 32'(data), 32'hC3);
    ready = 1'b1; step();

    // Hysteresis on pin 1.
    do_reset();
    v = mkbus(8'h02, 8'h00);
    repeat (10) step();
    set_pin(1, TH_HI_DEF - 16'sd1);
    repeat (10) step();
    do_capture(TIMEOUT + 4, lat);
    check("hys_hi_minus1_lat", 32'(lat), 32'(TIMEOUT));
    check("hys_hi_minus1_to", 32'(timeout), 32'd1);
    check("hys_hi_minus1_data", 32'(data), 32'h02);
    step();
    set_pin(1, TH_LO_DEF + 16'sd1);
    repeat (10) step();
    do_capture(TIMEOUT + 4, lat);
    check("hys_lo_plus1_to", 32'(timeout), 32'd1);
    check("hys_lo_plus1_data", 32'(data), 32'h02);
    step();
    set_pin(1, TH_LO_DEF);
    repeat (10) step();
    do_capture(TIMEOUT + 4, lat);
    check("hys_at_lo_lat", 32'(lat), 32'd1);
    check("hys_at_lo_to", 32'(timeout), 32'd0);
    check("hys_at_lo_data", 32'(data), 32'h00);
    step();

    // Asynchronous reset mid-WAIT and in HOLD.
    do_reset();
    v = mkbus(8'hFF, 8'h20);
    repeat (10) step();
    req = 1'b1; ready = 1'b0; step(); req = 1'b0;
    repeat (5) step();
    req = 1'b1; step(); req = 1'b0;
    check("ar_wait_overrun", 32'(overrun), 32'd1);
    #2 ereset_n = 1'b0;
    #1;
    check("ar_wait_valid", 32'(valid), 32'd0);
    check("ar_wait_overrun0", 32'(overrun), 32'd0);
    model_reset();
    step();
    ereset_n = 1'b1;
    req = 1'b1; step(); req = 1'b0;
    lat = -1;
    for (int c = 1; c <= TIMEOUT + 4; c++) begin
      step();
      if (valid === 1'b1) begin lat = c; break; end
    end
    check("ar_hold_lat", 32'(lat), 32'(TIMEOUT));
    check("ar_hold_data", 32'(data), 32'hDF);
    check("ar_hold_to", 32'(timeout), 32'd1);
    #2 ereset_n = 1'b0;
    #1;
    check("ar_hold_valid0", 32'(valid), 32'd0);
    check("ar_hold_data0", 32'(data), 32'd0);
    check("ar_hold_to0", 32'(timeout), 32'd0);
    model_reset();
    step();
    ereset_n = 1'b1;
    v = mkbus(8'h81, 8'h00);
    repeat (10) step();
    do_capture(TIMEOUT + 4, lat);
    check("ar_after_lat", 32'(lat), 32'd1);
    check("ar_after_data", 32'(data), 32'h81);
    step();

    // Randomized traffic against the model.
    ready = 1'b0; req = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(6))
          0: rv = V_HI;
          1: rv = V_LO;
          2: rv = TH_HI_DEF;
          3: rv = TH_LO_DEF;
          4: rv = TH_HI_DEF - 16'sd1;
          5: rv = TH_LO_DEF + 16'sd1;
          default: rv = 16'($urandom);
        endcase
        set_pin(int'($urandom_range(N - 1)), rv);
      end
      req         = ($urandom_range(5) == 0);
      ready       = ($urandom_range(1) == 0);
      clr_overrun = ($urandom_range(19) == 0);
      step();
    end
    req = 1'b0; ready = 1'b0; clr_overrun = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
